// File: rtl/coa_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   - Opcode constants (instr[31:26]) for Halt and the branch family.
//   - Fetch sequencer state enumeration.
//   - Small decode helpers used by the fetch logic.
package coa_pkg;

  localparam logic [5:0] OP_HALT = 6'b111000;
  localparam logic [5:0] OP_BR   = 6'b011000;
  localparam logic [5:0] OP_BMI  = 6'b011001;
  localparam logic [5:0] OP_BZ   = 6'b011011;

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10,
    FAULT  = 2'b11
  } fetch_state_e;

  // True when the instruction's opcode field matches the given Halt opcode.
  function automatic logic is_halt(input logic [31:0] instr, input logic [5:0] halt_op);
    return (instr[31:26] == halt_op);
  endfunction

  // True for any of the control-transfer opcodes resolved in execute.
  function automatic logic is_branch(input logic [31:0] instr);
    return (instr[31:26] == OP_BR) || (instr[31:26] == OP_BMI) || (instr[31:26] == OP_BZ);
  endfunction

endpackage

// File: rtl/ifetch_sequencer_if.sv
// Bundle of the fetch sequencer's memory, decode-handshake, execute-redirect
// and status signals.
//   master : the fetch sequencer (drives PC/IR/status, samples memory data,
//            decode ready, redirects and halt commit)
//   slave  : the surrounding pipeline / memory (the opposite directions)
interface ifetch_sequencer_if;

  logic [31:0] imem_addr;        // word index into instruction memory (= PC)
  logic [31:0] imem_data;        // combinational read data for imem_addr
  logic [31:0] ir;               // latched instruction
  logic [31:0] ir_pc;            // PC of the instruction held in ir
  logic        ir_valid;         // ir holds an undelivered instruction
  logic        ir_ready;         // decode accepts ir this cycle
  logic        redirect_valid;   // execute redirects fetch, flushing ir
  logic [31:0] redirect_target;  // absolute word index of the new PC
  logic        halt_commit;      // pending Halt has retired
  logic        halted;           // sticky: Halt committed
  logic        fault;            // sticky: fetch attempted out of range
  logic [31:0] fetch_count;      // instructions accepted by decode

  modport master (
    output imem_addr,
    input  imem_data,
    output ir,
    output ir_pc,
    output ir_valid,
    input  ir_ready,
    input  redirect_valid,
    input  redirect_target,
    input  halt_commit,
    output halted,
    output fault,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  ir,
    input  ir_pc,
    input  ir_valid,
    output ir_ready,
    output redirect_valid,
    output redirect_target,
    output halt_commit,
    input  halted,
    input  fault,
    input  fetch_count
  );

endinterface

// File: rtl/ifetch_sequencer.sv
// Fetch controller for a word-indexed, combinational-read instruction memory.
// Owns the PC, latches one instruction at a time into a single IR slot that
// is handed to decode with a valid/ready handshake, follows execute
// redirects, pauses after fetching a Halt until it commits or is squashed,
// and stops with a sticky fault on a fetch at PC >= DEPTH.
//
// Ports:
//   clk  : single clock, all state updates on posedge
//   rsta : synchronous active-high reset
//   bus  : ifetch_sequencer_if.master (memory address/data, IR handshake,
//          redirect, halt commit, halted/fault status, fetch counter)
//
// All outputs are taken straight from registers; imem_addr is the PC.
module ifetch_sequencer
  import coa_pkg::*;
#(
  parameter int unsigned DEPTH       = 128,
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter logic [5:0]  HALT_OPCODE = OP_HALT
) (
  input  logic clk,
  input  logic rsta,
  ifetch_sequencer_if.master bus
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  fetch_state_e state_r, state_n;
  logic [31:0]  pc_r, pc_n;
  logic [31:0]  ir_r, ir_n;
  logic [31:0]  ir_pc_r, ir_pc_n;
  logic         ir_valid_r, ir_valid_n;
  logic         halted_r, halted_n;
  logic         fault_r, fault_n;
  logic [31:0]  fetch_count_r, fetch_count_n;
  logic         accept_s;
  logic         slot_free_s;

  // Next-state, fetch decision and handshake accounting.
  always_comb begin
    state_n     = state_r;
    pc_n        = pc_r;
    ir_n        = ir_r;
    ir_pc_n     = ir_pc_r;
    ir_valid_n  = ir_valid_r;
    halted_n    = halted_r;
    fault_n     = fault_r;
    accept_s    = 1'b0;
    slot_free_s = (~ir_valid_r) | bus.ir_ready;

    case (state_r)
      FETCH: begin
        accept_s = ir_valid_r & bus.ir_ready;
        if (bus.redirect_valid) begin
          // Redirect cycle never fetches; the new target is range-checked
          // only when it is actually fetched on a later edge.
          pc_n       = bus.redirect_target;
          ir_valid_n = 1'b0;
        end else if (slot_free_s) begin
          if (pc_r < DEPTH_W) begin
            ir_n       = bus.imem_data;
            ir_pc_n    = pc_r;
            ir_valid_n = 1'b1;
            pc_n       = pc_r + 32'd1;
            if (is_halt(bus.imem_data, HALT_OPCODE)) begin
              state_n = DRAIN;
            end else begin
              state_n = FETCH;
            end
          end else begin
            fault_n    = 1'b1;
            ir_valid_n = 1'b0;
            state_n    = FAULT;
          end
        end else begin
          // Decode stalled with an occupied slot: hold PC and IR.
          ir_valid_n = ir_valid_r;
        end
      end

      DRAIN: begin
        accept_s = ir_valid_r & bus.ir_ready;
        if (bus.redirect_valid) begin
          // Halt was on a mispredicted path; resume fetching at the target.
          pc_n       = bus.redirect_target;
          ir_valid_n = 1'b0;
          state_n    = FETCH;
        end else if (bus.halt_commit) begin
          halted_n   = 1'b1;
          ir_valid_n = 1'b0;
          state_n    = HALTED;
        end else if (accept_s) begin
          // The Halt (or whatever is in IR) has been delivered; nothing follows.
          ir_valid_n = 1'b0;
        end else begin
          ir_valid_n = ir_valid_r;
        end
      end

      HALTED: begin
        ir_valid_n = 1'b0;
      end

      FAULT: begin
        ir_valid_n = 1'b0;
      end

      default: begin
        // Unreachable encoding: park safely in FAULT with no valid IR.
        state_n    = FAULT;
        fault_n    = 1'b1;
        ir_valid_n = 1'b0;
      end
    endcase

    fetch_count_n = fetch_count_r + {31'd0, accept_s};
  end

  // PC, IR, status and state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rsta) begin
      state_r       <= FETCH;
      pc_r          <= RESET_PC;
      ir_r          <= 32'd0;
      ir_pc_r       <= 32'd0;
      ir_valid_r    <= 1'b0;
      halted_r      <= 1'b0;
      fault_r       <= 1'b0;
      fetch_count_r <= 32'd0;
    end else begin
      state_r       <= state_n;
      pc_r          <= pc_n;
      ir_r          <= ir_n;
      ir_pc_r       <= ir_pc_n;
      ir_valid_r    <= ir_valid_n;
      halted_r      <= halted_n;
      fault_r       <= fault_n;
      fetch_count_r <= fetch_count_n;
    end
  end

  assign bus.imem_addr   = pc_r;
  assign bus.ir          = ir_r;
  assign bus.ir_pc       = ir_pc_r;
  assign bus.ir_valid    = ir_valid_r;
  assign bus.halted      = halted_r;
  assign bus.fault       = fault_r;
  assign bus.fetch_count = fetch_count_r;

endmodule

// File: tb/tb_ifetch_sequencer.sv
module tb_ifetch_sequencer;
  import coa_pkg::*;

  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic rsta;
  always #5 clk = ~clk;

  ifetch_sequencer_if bus();

  logic [31:0] mem [0:DEPTH-1];

  // Combinational instruction memory; out-of-range reads return zero.
  assign bus.imem_data = (bus.imem_addr < 32'd128) ? mem[bus.imem_addr[6:0]] : 32'h0000_0000;

  ifetch_sequencer #(
    .DEPTH(DEPTH),
    .RESET_PC(32'd0),
    .HALT_OPCODE(OP_HALT)
  ) dut (
    .clk(clk),
    .rsta(rsta),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: what the pipeline front end should look like.
  logic [31:0] m_pc, m_ir, m_ir_pc, m_count;
  logic        m_irv, m_halted, m_fault;
  logic        m_waiting_commit;  // a Halt has been fetched and not resolved
  logic        m_stopped;         // halted or faulted; only reset revives

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("imem_addr", bus.imem_addr, m_pc);
    check("ir_valid", {31'd0, bus.ir_valid}, {31'd0, m_irv});
    check("ir", bus.ir, m_ir);
    check("ir_pc", bus.ir_pc, m_ir_pc);
    check("halted", {31'd0, bus.halted}, {31'd0, m_halted});
    check("fault", {31'd0, bus.fault}, {31'd0, m_fault});
    check("fetch_count", bus.fetch_count, m_count);
  endtask

  // Apply one cycle of inputs, advance the model, clock, then compare.
  task automatic step(input logic rst, input logic rdy, input logic rv,
                      input logic [31:0] tgt, input logic hc);
    logic        accept;
    logic [31:0] w;
    rsta                = rst;
    bus.ir_ready        = rdy;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    bus.halt_commit     = hc;

    accept = m_irv && rdy && !m_stopped;
    if (rst) begin
      m_pc = 32'd0; m_ir = 32'd0; m_ir_pc = 32'd0; m_count = 32'd0;
      m_irv = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
      m_waiting_commit = 1'b0; m_stopped = 1'b0;
    end else if (!m_stopped) begin
      if (accept) m_count = m_count + 32'd1;
      if (rv) begin
        m_pc = tgt;
        m_irv = 1'b0;
        m_waiting_commit = 1'b0;
      end else if (m_waiting_commit) begin
        if (hc) begin
          m_halted = 1'b1;
          m_irv = 1'b0;
          m_stopped = 1'b1;
        end else if (accept) begin
          m_irv = 1'b0;
        end
      end else if (!m_irv || rdy) begin
        if (m_pc < 32'd128) begin
          w = mem[m_pc[6:0]];
          m_ir = w;
          m_ir_pc = m_pc;
          m_irv = 1'b1;
          m_pc = m_pc + 32'd1;
          if (w[31:26] == OP_HALT) m_waiting_commit = 1'b1;
        end else begin
          m_fault = 1'b1;
          m_irv = 1'b0;
          m_stopped = 1'b1;
        end
      end
    end

    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] tgt;
    int          guard;

    rsta = 1'b1;
    bus.ir_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'd0;
    bus.halt_commit = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      if (w[31:26] == OP_HALT) w[31:26] = 6'b000000;
      mem[i] = w;
    end
    mem[0]  = 32'h2001_0012;   // addi r1,r0,18
    mem[1]  = 32'h2002_000C;   // addi r2,r0,12
    mem[2]  = 32'h0422_1800;   // sub  r3,r1,r2
    mem[11] = 32'hE000_0000;   // halt
    mem[60] = 32'hE000_0000;   // halt

    // Reset state
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);

    // Streaming fetch, first instruction one edge after reset release
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    check("ir_at_pc0", bus.ir, 32'h2001_0012);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    check("ir_pc_2", bus.ir_pc, 32'd2);

    // Decode stall for three cycles
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    check("stall_addr", bus.imem_addr, 32'd3);
    check("stall_count", bus.fetch_count, 32'd2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    check("ir_pc_6", bus.ir_pc, 32'd6);

    // Redirect to 2: flush now, target in IR one edge later
    step(1'b0, 1'b1, 1'b1, 32'd2, 1'b0);
    check("redir_flush", {31'd0, bus.ir_valid}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    check("redir_ir", bus.ir, 32'h0422_1800);

    // Run up to the Halt at 11
    guard = 0;
    while (!m_waiting_commit && guard < 20) begin
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      guard++;
    end
    check("halt_fetched_pc", bus.ir_pc, 32'd11);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    check("drain_addr", bus.imem_addr, 32'd12);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    check("halted_set", {31'd0, bus.halted}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 32'd5, 1'b0);
    check("halted_ignores_redir", bus.imem_addr, 32'd12);

    // Speculative Halt squashed by a redirect arriving with halt_commit
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'd9, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'd5, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    check("squash_ir_pc", bus.ir_pc, 32'd5);
    check("squash_not_halted", {31'd0, bus.halted}, 32'd0);

    // Run off the end of memory: 126, 127, then fault at 128
    step(1'b0, 1'b1, 1'b1, 32'd126, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    check("end_fault", {31'd0, bus.fault}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 32'd3, 1'b1);

    // Out-of-range redirect target 130, reset mid-FAULT
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'd130, 1'b0);
    check("redir_no_early_fault", {31'd0, bus.fault}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    check("fault_130", {31'd0, bus.fault}, 32'd1);
    check("fault_irv", {31'd0, bus.ir_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    check("rst_fault_clear", {31'd0, bus.fault}, 32'd0);
    check("rst_pc", bus.imem_addr, 32'd0);

    // Full 32-bit range check
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    check("fault_top", {31'd0, bus.fault}, 32'd1);

    // Randomized traffic against the model
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      tgt = 32'($urandom_range(0, 135));
      if ($urandom_range(0, 49) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0),
           tgt,
           ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
